shift_arbiter: RTL
==================

# shift_arbiter

Round-robin arbiter that shares one 4-bit shift/rotate unit between two requesters over valid/ready handshakes. Each granted request is executed in one cycle and its result is held in a single-entry output register tagged with the requester id until the consumer takes it. It sits between the two client blocks that issue shift operations and the shared shift/rotate datapath. A wrapping operation counter is included for performance monitoring.

## Interface
- CNT_W, 8, width of the completed-operation counter
- clk  in  1  clock; all logic is on the rising edge
- rst_n  in  1  reset; synchronous, active-low
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_data  in  4  requester 0 operand
- req0_shift  in  2  requester 0 shift amount, 0..3
- req0_mode  in  2  requester 0 mode: 00 shl, 01 shr, 10 rol, 11 ror
- req1_valid / req1_ready / req1_data / req1_shift / req1_mode: same as requester 0, for requester 1
- res_valid  out  1  result register holds a result
- res_ready  in  1  consumer takes the result
- res_data  out  4  shifted/rotated result
- res_id  out  1  id of the requester that owns the result (0/1)
- ops_done  out  CNT_W  count of results consumed; wraps modulo 2^CNT_W

## Operation
- State machine with two states:
  - EMPTY: result register invalid.
  - FULL: result register valid.
- can_accept = (state==EMPTY) | res_ready.
- Grant, evaluated only when can_accept:
  - If exactly one reqN_valid is high, grant that requester.
  - If both are high, grant the requester that is not last_grant.
- reqN_ready = can_accept & grant==N. It is combinational, and at most one ready is high per cycle.
- On a grant:
  - Load res_data with the shift function of the granted operand.
  - Load res_id with N and set last_grant to N.
  - Go to (or stay in) FULL.
- If FULL and res_ready is high with no valid request: go to EMPTY.
- Shift function (logical shifts zero-fill):
  - shl = (d<<s) truncated to 4 bits.
  - shr = d>>s.
  - rol by s = {d[3-s:0], d[3:4-s]}.
  - ror by s = rol by (4-s) mod 4.
  - s=0 returns d unchanged in every mode.
- ops_done increments by 1 in every cycle where res_valid & res_ready. It wraps from all-ones to 0.
- Inputs of non-granted requesters are ignored. Requesters hold valid and payload until ready; the block does not check this.

## Timing
- Reset (rst_n low at a clock edge) sets:
  - state=EMPTY, res_valid=0, res_data=0, res_id=0, ops_done=0.
  - last_grant=1, so requester 0 wins the first contention.
  - While rst_n is low, req0_ready and req1_ready are forced to 0.
- Latency: an operation accepted at edge k appears on res_valid/res_data at the output after edge k. This is 1 cycle.
- Throughput: one operation per cycle when res_ready stays high (back-to-back replacement in FULL).
- Simultaneous consume and accept in FULL: the old result is consumed and counted, and the new result replaces it in the same edge. res_valid stays 1.
- Backpressure: FULL with res_ready=0 gives both readies 0. res_* outputs stay stable.
- Reset mid-operation: a pending result is discarded without being counted, and arbitration priority returns to requester 0.
- Counter wrap: at ops_done = 2^CNT_W−1, the next consume gives 0.

## Structure
- Shared package `shift_pkg`:
  - Mode encoding constants: MODE_SHL=2'b00, MODE_SHR=2'b01, MODE_ROL=2'b10, MODE_ROR=2'b11.
  - State encoding: ST_EMPTY, ST_FULL.
- Sub-module `shift_unit`: purely combinational, 4-bit operand, 2-bit shift, 2-bit mode, 4-bit result.
  - Instantiated once, fed by the grant mux.
  - Reusable by other clients.
- Arbitration, result register and counter live in shift_arbiter.

## Test plan
- Reset, then req0 only: data=1011, shift=1, mode=rol, with res_ready=1.
  - Required: req0_ready high for 1 cycle.
  - Next cycle: res_valid=1, res_data=0111, res_id=0.
  - After consume: ops_done=1.
- Both requesters valid every cycle with res_ready=1:
  - req0: 1011, shr 2.
  - req1: 1001, ror 1.
  - Required: grants alternate 0,1,0,1; results alternate 0010/id0 and 1100/id1. Requester 0 wins the first cycle after reset.
- Backpressure: res_ready=0 for 3 cycles after one result, with both requesters valid.
  - Required: both readies stay 0 and res_data/res_id stay stable.
  - When res_ready rises: the held result is consumed and a new grant is taken in the same edge.
- Mode/shift sweep through req1 on all 256 data×shift×mode combinations.
  - res_data matches the shift function, e.g. 1011 shl 1 gives 0110 and s=0 gives the operand unchanged.
- Reset mid-operation: assert rst_n=0 while FULL.
  - Required: res_valid=0 and ops_done=0 after the edge.
  - With both requesters valid afterwards, the first grant goes to requester 0.
- CNT_W=2: perform 5 consumes. Required: ops_done sequence 1,2,3,0,1.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared encodings for the shift/rotate unit and its arbiter.
// No logic; types and constants only.
package shift_pkg;

    localparam logic [1:0] MODE_SHL = 2'b00;
    localparam logic [1:0] MODE_SHR = 2'b01;
    localparam logic [1:0] MODE_ROL = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // One shift request as presented by a client.
    typedef struct packed {
        logic [3:0] dat;
        logic [1:0] shift;
        logic [1:0] mode;
    } op_t;

endpackage

// File: rtl/shift_unit.sv
// 4-bit logical shift / rotate, modes shl, shr, rol, ror by 0..3.
// Latency: 0 cycles, purely combinational.
// Backpressure: none, no state.
module shift_unit
    import shift_pkg::*;
(
    input  logic [3:0] data,
    input  logic [1:0] shift,
    input  logic [1:0] mode,
    output logic [3:0] result
);

    logic [7:0] dbl_l;
    logic [7:0] dbl_r;

    // Rotations come from shifting the operand concatenated with itself.
    always_comb begin
        dbl_l  = {data, data} << shift;
        dbl_r  = {data, data} >> shift;
        result = data;
        case (mode)
            MODE_SHL: result = data << shift;
            MODE_SHR: result = data >> shift;
            MODE_ROL: result = dbl_l[7:4];
            MODE_ROR: result = dbl_r[3:0];
            default:  result = data;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin share of one shift_unit between two requesters, single-entry result register.
// Latency: 1 cycle from accept to res_valid; one op per cycle while res_ready stays high.
// Backpressure: result held and both readies low while full and res_ready is low.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_data,
    input  logic [1:0]       req0_shift,
    input  logic [1:0]       req0_mode,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_data,
    input  logic [1:0]       req1_shift,
    input  logic [1:0]       req1_mode,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [3:0]       res_data,
    output logic             res_id,
    output logic [CNT_W-1:0] ops_done
);

    state_t     state;
    logic       last_grant;
    op_t        op0;
    op_t        op1;
    op_t        gnt_op;
    logic       gnt_vld;
    logic       gnt_id;
    logic       can_accept;
    logic       accept;
    logic       consume;
    logic [3:0] shift_res;

    assign op0 = '{dat: req0_data, shift: req0_shift, mode: req0_mode};
    assign op1 = '{dat: req1_data, shift: req1_shift, mode: req1_mode};

    // With both requesting, the one not served last wins; otherwise the lone requester.
    assign gnt_vld = req0_valid | req1_valid;
    assign gnt_id  = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    assign gnt_op  = gnt_id ? op1 : op0;

    assign res_valid  = (state == ST_FULL);
    assign can_accept = (state == ST_EMPTY) | res_ready;
    assign accept     = rst_n & can_accept & gnt_vld;
    assign consume    = res_valid & res_ready;

    assign req0_ready = accept & ~gnt_id;
    assign req1_ready = accept & gnt_id;

    shift_unit u_shift (
        .data   (gnt_op.dat),
        .shift  (gnt_op.shift),
        .mode   (gnt_op.mode),
        .result (shift_res)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_EMPTY;
            res_data   <= 4'd0;
            res_id     <= 1'b0;
            last_grant <= 1'b1;
            ops_done   <= '0;
        end else begin
            if (consume) begin
                ops_done <= ops_done + CNT_W'(1);
            end
            if (accept) begin
                res_data   <= shift_res;
                res_id     <= gnt_id;
                last_grant <= gnt_id;
                state      <= ST_FULL;
            end else if (consume) begin
                state <= ST_EMPTY;
            end
        end
    end

endmodule
